ras_ckpt: RTL and testbench
===========================

# ras_ckpt

Parametrised circular return-address stack with speculative checkpoint/repair for the frontend branch predictor. Calls push, returns pop, and the top entry drives return-target prediction. On a predicted branch the frontend takes a checkpoint of the stack pointer, occupancy and top entry. On a mispredict the frontend restores that checkpoint by id, undoing wrong-path pushes and pops without a full flush.

## Interface
- DEPTH, default 8: number of stack entries; power of two, ≥2.
- VLEN, default 64: return-address width in bits.
- NR_CKPT, default 4: number of checkpoint slots; power of two, ≥2.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, active-low and asynchronous (one clock; reset is asynchronous and active-low).
- flush_i  in  1  clears the stack and invalidates all checkpoints.
- push_i  in  1  push data_i.
- pop_i  in  1  pop the top entry.
- data_i  in  VLEN  return address to push.
- ckpt_i  in  1  capture a checkpoint into slot ckpt_id_i.
- ckpt_id_i  in  $clog2(NR_CKPT)  checkpoint slot to write.
- restore_i  in  1  restore from slot restore_id_i.
- restore_id_i  in  $clog2(NR_CKPT)  checkpoint slot to read.
- ra_o  out  VLEN  top-of-stack return address; 0 when empty.
- valid_o  out  1  stack non-empty (count_o != 0).
- count_o  out  $clog2(DEPTH+1)  occupancy, saturating at DEPTH.

## Operation
- State:
  - stack[DEPTH] of {ra, valid}.
  - tos pointer, $clog2(DEPTH) bits; points at the top entry; arithmetic wraps modulo DEPTH.
  - count, 0..DEPTH.
  - NR_CKPT slots of {vld, tos, count, top_ra, top_valid}.
- Outputs are functions of registered state only: ra_o = stack[tos].ra when count != 0, else 0.
- Push only:
  - tos <= tos+1.
  - stack[tos+1] <= {data_i, 1}.
  - count <= min(count+1, DEPTH).
  - When full, the oldest entry is overwritten silently (wrap-around); count stays DEPTH.
- Pop only:
  - count != 0: tos <= tos-1, count <= count-1, popped entry's valid <= 0.
  - count == 0: no state change.
- Push and pop in the same cycle:
  - stack[tos] <= {data_i, 1}; tos unchanged.
  - count unchanged, except an empty stack becomes count = 1.
- Checkpoint (ckpt_i, no restore_i, no flush_i):
  - Slot ckpt_id_i <= {1, tos, count, stack[tos].ra, stack[tos].valid}, all sampled before this cycle's push/pop.
  - Overwrites any prior content of the slot.
- Restore (restore_i, no flush_i), applied only if slot restore_id_i has vld = 1:
  - tos <= slot.tos, count <= slot.count.
  - stack[slot.tos] <= {slot.top_ra, slot.top_valid}.
  - push_i, pop_i and ckpt_i in the same cycle are ignored.
  - Restore of a slot with vld = 0: no state change; push/pop still ignored.
  - Slot vld is not cleared by restore; the same slot may be restored repeatedly.
- Repair is top-entry-only. Deeper entries overwritten by wrong-path pushes are not recovered. This is accepted predictor inaccuracy, not an error.
- Flush: stack, tos and count <= 0; all slot vld <= 0. Overrides every other input.
- Priority: flush_i > restore_i > push_i/pop_i; ckpt_i is independent of push/pop.

## Timing
- Reset (asynchronous, mid-operation allowed): all state 0; ra_o = 0, valid_o = 0, count_o = 0 immediately, with no clock required.
- Every operation takes effect at the next rising edge. Outputs reflect it one cycle after the input is asserted.
- No combinational path from any input to any output.
- No handshake; every input is accepted every cycle, and no back-pressure is provided.

## Test plan
- Basic LIFO, DEPTH = 4:
  - Push 0x100, 0x200, 0x300 on three edges -> ra_o = 0x300, count_o = 3.
  - Then three pops -> ra_o = 0x200, 0x100, then 0 with valid_o = 0.
  - A fourth pop leaves count_o = 0.
- Overflow:
  - Push 0x1..0x6 into DEPTH = 4 -> count_o = 4, ra_o = 0x6.
  - Four pops return 0x5, 0x4, 0x3 in turn, then valid_o = 0; count_o reaches 0.
- Simultaneous push and pop:
  - Stack {0x10, 0x20 top}; push+pop with data_i = 0x30 -> ra_o = 0x30, count_o = 2.
  - On an empty stack, the same stimulus gives count_o = 1.
- Checkpoint/restore:
  - Stack {0xA, 0xB top}; ckpt id 2.
  - Then pop, pop, push 0xC, push 0xD, then restore id 2 -> ra_o = 0xB, count_o = 2.
  - A restore to an unused id causes no change.
- Priority:
  - flush_i + restore_i + push_i together -> count_o = 0.
  - A following restore of any id causes no change.
  - restore_i + push_i together -> push is dropped.
- Async reset mid-operation:
  - Assert rst_ni low between edges while count_o = 3 -> all outputs 0 before the next edge.
  - Restore to an earlier id after deassertion causes no change.

Source files
------------

// File: rtl/ras_ckpt.sv
// ras_ckpt: circular return-address stack with speculative checkpoint/repair.
// Calls push and returns pop. The top entry predicts the return target.
// Checkpoints hold {tos, count, top entry}. A restore rolls the stack back
// to a checkpoint; only the top entry is repaired.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   flush_i                  clear stack and invalidate all checkpoints
//   push_i, pop_i, data_i    stack operations (push+pop replaces the top)
//   ckpt_i, ckpt_id_i        capture a checkpoint into a slot
//   restore_i, restore_id_i  restore from a slot (ignored if the slot is invalid)
//   ra_o, valid_o, count_o   registered top address, non-empty flag, occupancy
module ras_ckpt #(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned VLEN    = 64,
   parameter int unsigned NR_CKPT = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [VLEN-1:0]              data_i,
   input  logic                         ckpt_i,
   input  logic [$clog2(NR_CKPT)-1:0]   ckpt_id_i,
   input  logic                         restore_i,
   input  logic [$clog2(NR_CKPT)-1:0]   restore_id_i,
   output logic [VLEN-1:0]              ra_o,
   output logic                         valid_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int unsigned TW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   // Stack storage and pointers
   logic [VLEN-1:0] stk_ra_q  [DEPTH];
   logic [VLEN-1:0] stk_ra_d  [DEPTH];
   logic [DEPTH-1:0] stk_vld_q, stk_vld_d;
   logic [TW-1:0]   tos_q, tos_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   // Checkpoint slots
   logic [NR_CKPT-1:0] ck_vld_q, ck_vld_d;
   logic [TW-1:0]   ck_tos_q [NR_CKPT];
   logic [TW-1:0]   ck_tos_d [NR_CKPT];
   logic [CW-1:0]   ck_cnt_q [NR_CKPT];
   logic [CW-1:0]   ck_cnt_d [NR_CKPT];
   logic [VLEN-1:0] ck_ra_q  [NR_CKPT];
   logic [VLEN-1:0] ck_ra_d  [NR_CKPT];
   logic [NR_CKPT-1:0] ck_rv_q, ck_rv_d;

   // Registered outputs
   logic [VLEN-1:0] ra_q, ra_d;
   logic            valid_q, valid_d;

   logic [TW-1:0]   tos_inc, tos_dec;

   // Next-state logic: flush > restore > push/pop; ckpt runs alongside push/pop
   always_comb begin
      stk_ra_d  = stk_ra_q;
      stk_vld_d = stk_vld_q;
      tos_d     = tos_q;
      cnt_d     = cnt_q;
      ck_vld_d  = ck_vld_q;
      ck_tos_d  = ck_tos_q;
      ck_cnt_d  = ck_cnt_q;
      ck_ra_d   = ck_ra_q;
      ck_rv_d   = ck_rv_q;
      tos_inc   = TW'(tos_q + TW'(1));
      tos_dec   = TW'(tos_q - TW'(1));

      if (flush_i) begin
         for (int i = 0; i < DEPTH; i++) stk_ra_d[i] = '0;
         stk_vld_d = '0;
         tos_d     = '0;
         cnt_d     = '0;
         ck_vld_d  = '0;
      end else if (restore_i) begin
         // Invalid slot: nothing changes, and push/pop are still dropped
         if (ck_vld_q[restore_id_i]) begin
            tos_d                            = ck_tos_q[restore_id_i];
            cnt_d                            = ck_cnt_q[restore_id_i];
            stk_ra_d[ck_tos_q[restore_id_i]]  = ck_ra_q[restore_id_i];
            stk_vld_d[ck_tos_q[restore_id_i]] = ck_rv_q[restore_id_i];
         end
      end else begin
         // Snapshot is taken from the current-cycle state, before push/pop
         if (ckpt_i) begin
            ck_vld_d[ckpt_id_i] = 1'b1;
            ck_tos_d[ckpt_id_i] = tos_q;
            ck_cnt_d[ckpt_id_i] = cnt_q;
            ck_ra_d[ckpt_id_i]  = stk_ra_q[tos_q];
            ck_rv_d[ckpt_id_i]  = stk_vld_q[tos_q];
         end
         if (push_i && pop_i) begin
            stk_ra_d[tos_q]  = data_i;
            stk_vld_d[tos_q] = 1'b1;
            if (cnt_q == '0) cnt_d = CW'(1);
         end else if (push_i) begin
            // When full this silently overwrites the oldest entry
            tos_d              = tos_inc;
            stk_ra_d[tos_inc]  = data_i;
            stk_vld_d[tos_inc] = 1'b1;
            if (cnt_q != CW'(DEPTH)) cnt_d = CW'(cnt_q + CW'(1));
         end else if (pop_i && (cnt_q != '0)) begin
            tos_d            = tos_dec;
            cnt_d            = CW'(cnt_q - CW'(1));
            stk_vld_d[tos_q] = 1'b0;
         end
      end

      valid_d = (cnt_d != '0);
      ra_d    = valid_d ? stk_ra_d[tos_d] : '0;
   end

   // State registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) stk_ra_q[i] <= '0;
         stk_vld_q <= '0;
         tos_q     <= '0;
         cnt_q     <= '0;
         ck_vld_q  <= '0;
         ck_rv_q   <= '0;
         for (int j = 0; j < NR_CKPT; j++) begin
            ck_tos_q[j] <= '0;
            ck_cnt_q[j] <= '0;
            ck_ra_q[j]  <= '0;
         end
         ra_q      <= '0;
         valid_q   <= 1'b0;
      end else begin
         stk_ra_q  <= stk_ra_d;
         stk_vld_q <= stk_vld_d;
         tos_q     <= tos_d;
         cnt_q     <= cnt_d;
         ck_vld_q  <= ck_vld_d;
         ck_tos_q  <= ck_tos_d;
         ck_cnt_q  <= ck_cnt_d;
         ck_ra_q   <= ck_ra_d;
         ck_rv_q   <= ck_rv_d;
         ra_q      <= ra_d;
         valid_q   <= valid_d;
      end
   end

   assign ra_o    = ra_q;
   assign valid_o = valid_q;
   assign count_o = cnt_q;

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt (DEPTH=4, VLEN=16, NR_CKPT=4).
module tb_ras_ckpt;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned VLEN    = 16;
   localparam int unsigned NR_CKPT = 4;

   logic            clk, rst_n;
   logic            flush, push, pop, ckpt, restore;
   logic [VLEN-1:0] data;
   logic [1:0]      ckpt_id, restore_id;
   logic [VLEN-1:0] ra;
   logic            valid;
   logic [2:0]      count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic            flush, push, pop;
      logic [VLEN-1:0] data;
      logic            ckpt;
      logic [1:0]      cid;
      logic            restore;
      logic [1:0]      rid;
      logic [VLEN-1:0] e_ra;
      logic            e_v;
      logic [2:0]      e_cnt;
   } vec_t;

   vec_t vecs[$];

   ras_ckpt #(.DEPTH(DEPTH), .VLEN(VLEN), .NR_CKPT(NR_CKPT)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .push_i(push), .pop_i(pop),
      .data_i(data), .ckpt_i(ckpt), .ckpt_id_i(ckpt_id), .restore_i(restore),
      .restore_id_i(restore_id), .ra_o(ra), .valid_o(valid), .count_o(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic f, input logic pu, input logic po,
                               input logic [VLEN-1:0] d, input logic ck, input logic [1:0] cid,
                               input logic rs, input logic [1:0] rid,
                               input logic [VLEN-1:0] era, input logic ev, input logic [2:0] ec);
      vec_t v;
      v.flush = f; v.push = pu; v.pop = po; v.data = d; v.ckpt = ck; v.cid = cid;
      v.restore = rs; v.rid = rid; v.e_ra = era; v.e_v = ev; v.e_cnt = ec;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, got, exp);
      end
   endtask

   task automatic check_out(input string nm, input int idx, input logic [VLEN-1:0] e_ra,
                            input logic e_v, input logic [2:0] e_cnt);
      chk({nm, ".ra"},    idx, 32'(ra),    32'(e_ra));
      chk({nm, ".valid"}, idx, 32'(valid), 32'(e_v));
      chk({nm, ".count"}, idx, 32'(count), 32'(e_cnt));
   endtask

   task automatic idle();
      flush = 0; push = 0; pop = 0; ckpt = 0; restore = 0;
      data = '0; ckpt_id = '0; restore_id = '0;
   endtask

   // Drive one vector away from the edge, then sample 1 time unit after the edge
   task automatic apply(input vec_t v);
      flush = v.flush; push = v.push; pop = v.pop; data = v.data;
      ckpt = v.ckpt; ckpt_id = v.cid; restore = v.restore; restore_id = v.rid;
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      #3;
      check_out("reset", 0, '0, 1'b0, 3'd0);
      #9 rst_n = 1'b1;

      //        f  pu po data     ck cid rs rid  e_ra     ev ec
      // Basic LIFO
      vecs.push_back(mk(0, 1, 0, 16'h100, 0, 0, 0, 0, 16'h100, 1, 1));
      vecs.push_back(mk(0, 1, 0, 16'h200, 0, 0, 0, 0, 16'h200, 1, 2));
      vecs.push_back(mk(0, 1, 0, 16'h300, 0, 0, 0, 0, 16'h300, 1, 3));
      vecs.push_back(mk(0, 0, 1, 16'h0,   0, 0, 0, 0, 16'h200, 1, 2));
      vecs.push_back(mk(0, 0, 1, 16'h0,   0, 0, 0, 0, 16'h100, 1, 1));
      vecs.push_back(mk(0, 0, 1, 16'h0,   0, 0, 0, 0, 16'h0,   0, 0));
      vecs.push_back(mk(0, 0, 1, 16'h0,   0, 0, 0, 0, 16'h0,   0, 0));
      // Overflow: 0x5 and 0x6 overwrite the oldest entries
      vecs.push_back(mk(0, 1, 0, 16'h1,   0, 0, 0, 0, 16'h1,   1, 1));
      vecs.push_back(mk(0, 1, 0, 16'h2,   0, 0, 0, 0, 16'h2,   1, 2));
      vecs.push_back(mk(0, 1, 0, 16'h3,   0, 0, 0, 0, 16'h3,   1, 3));
      vecs.push_back(mk(0, 1, 0, 16'h4,   0, 0, 0, 0, 16'h4,   1, 4));
      vecs.push_back(mk(0, 1, 0, 16'h5,   0, 0, 0, 0, 16'h5,   1, 4));
      vecs.push_back(mk(0, 1, 0, 16'h6,   0, 0, 0, 0, 16'h6,   1, 4));
      vecs.push_back(mk(0, 0, 1, 16'h0,   0, 0, 0, 0, 16'h5,   1, 3));
      vecs.push_back(mk(0, 0, 1, 16'h0,   0, 0, 0, 0, 16'h4,   1, 2));
      vecs.push_back(mk(0, 0, 1, 16'h0,   0, 0, 0, 0, 16'h3,   1, 1));
      vecs.push_back(mk(0, 0, 1, 16'h0,   0, 0, 0, 0, 16'h0,   0, 0));
      // Simultaneous push+pop
      vecs.push_back(mk(0, 1, 0, 16'h10,  0, 0, 0, 0, 16'h10,  1, 1));
      vecs.push_back(mk(0, 1, 0, 16'h20,  0, 0, 0, 0, 16'h20,  1, 2));
      vecs.push_back(mk(0, 1, 1, 16'h30,  0, 0, 0, 0, 16'h30,  1, 2));
      vecs.push_back(mk(0, 0, 1, 16'h0,   0, 0, 0, 0, 16'h10,  1, 1));
      vecs.push_back(mk(0, 0, 1, 16'h0,   0, 0, 0, 0, 16'h0,   0, 0));
      vecs.push_back(mk(0, 1, 1, 16'h40,  0, 0, 0, 0, 16'h40,  1, 1));
      vecs.push_back(mk(0, 0, 1, 16'h0,   0, 0, 0, 0, 16'h0,   0, 0));
      // Checkpoint / restore
      vecs.push_back(mk(0, 1, 0, 16'hA,   0, 0, 0, 0, 16'hA,   1, 1));
      vecs.push_back(mk(0, 1, 0, 16'hB,   0, 0, 0, 0, 16'hB,   1, 2));
      vecs.push_back(mk(0, 0, 0, 16'h0,   1, 2, 0, 0, 16'hB,   1, 2));
      vecs.push_back(mk(0, 0, 1, 16'h0,   0, 0, 0, 0, 16'hA,   1, 1));
      vecs.push_back(mk(0, 0, 1, 16'h0,   0, 0, 0, 0, 16'h0,   0, 0));
      vecs.push_back(mk(0, 1, 0, 16'hC,   0, 0, 0, 0, 16'hC,   1, 1));
      vecs.push_back(mk(0, 1, 0, 16'hD,   0, 0, 0, 0, 16'hD,   1, 2));
      vecs.push_back(mk(0, 0, 0, 16'h0,   0, 0, 1, 2, 16'hB,   1, 2));
      // Only the top is repaired: the entry below keeps the wrong-path 0xC
      vecs.push_back(mk(0, 0, 1, 16'h0,   0, 0, 0, 0, 16'hC,   1, 1));
      vecs.push_back(mk(0, 0, 0, 16'h0,   0, 0, 1, 0, 16'hC,   1, 1));
      vecs.push_back(mk(0, 0, 0, 16'h0,   0, 0, 1, 2, 16'hB,   1, 2));
      // Checkpoint samples pre-push state; restore drops a same-cycle push
      vecs.push_back(mk(0, 1, 0, 16'hE,   1, 1, 0, 0, 16'hE,   1, 3));
      vecs.push_back(mk(0, 1, 0, 16'hF,   0, 0, 1, 1, 16'hB,   1, 2));
      // Priority: flush wins, then all slots are invalid
      vecs.push_back(mk(1, 1, 0, 16'h77,  0, 0, 1, 2, 16'h0,   0, 0));
      vecs.push_back(mk(0, 0, 0, 16'h0,   0, 0, 1, 2, 16'h0,   0, 0));
      vecs.push_back(mk(0, 0, 0, 16'h0,   0, 0, 1, 1, 16'h0,   0, 0));
      vecs.push_back(mk(0, 1, 0, 16'h55,  0, 0, 0, 0, 16'h55,  1, 1));

      foreach (vecs[i]) begin
         apply(vecs[i]);
         check_out("vec", i, vecs[i].e_ra, vecs[i].e_v, vecs[i].e_cnt);
      end

      // Async reset mid-operation with a live checkpoint in slot 3
      apply(mk(0, 1, 0, 16'h66, 0, 0, 0, 0, 16'h0, 0, 0));
      apply(mk(0, 1, 0, 16'h67, 0, 0, 0, 0, 16'h0, 0, 0));
      apply(mk(0, 0, 0, 16'h0,  1, 3, 0, 0, 16'h0, 0, 0));
      check_out("pre_rst", 0, 16'h67, 1'b1, 3'd3);
      idle();
      #2 rst_n = 1'b0;
      #1 check_out("async_rst", 0, '0, 1'b0, 3'd0);
      #2 rst_n = 1'b1;
      apply(mk(0, 0, 0, 16'h0, 0, 0, 1, 3, 16'h0, 0, 0));
      check_out("rst_restore", 0, '0, 1'b0, 3'd0);
      apply(mk(0, 1, 0, 16'h99, 0, 0, 0, 0, 16'h0, 0, 0));
      check_out("post_rst_push", 0, 16'h99, 1'b1, 3'd1);

      idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
